gamepad_reader: RTL



---
 rtl/gamepad_if.sv | 36 +++
 rtl/gamepad_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gamepad_if.sv
// Signal bundle between gamepad_reader, the host that polls it and the serial pad.
interface gamepad_if;
  // Handshake: poll is a one-cycle request honoured only while busy=0; polls seen
  // while busy=1 are dropped. done and changed are one-cycle strobes with no
  // backpressure. buttons is a registered word, valid in every cycle.
  logic        poll;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] buttons;
  logic        busy;
  logic        done;
  logic        changed;

  modport master (
    output poll,
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  buttons,
    input  busy,
    input  done,
    input  changed
  );

  modport slave (
    input  poll,
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output buttons,
    output busy,
    output done,
    output changed
  );
endinterface

// File: rtl/gamepad_reader.sv
// Serial shift-register gamepad scanner: latch, clock out BUTTON_COUNT active-low bits,
// and commit the active-high word only when two consecutive scans agree.
module gamepad_reader #(
  parameter int CLK_DIV      = 8,
  parameter int BUTTON_COUNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  gamepad_if.slave   pad,
  output logic [2:0] dbg_state
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BUTTON_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_LOW    = 3'd2,
    S_HIGH   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] phase_q;
  logic [BW-1:0] bit_q;
  logic [15:0]   shift_q;
  logic [15:0]   prev_q;
  logic [15:0]   buttons_q;
  logic          sync_meta_q;
  logic          sync_q;

  logic          latch_end;
  logic          half_end;
  logic          bit_end;
  logic          scan_start;
  logic          sample_en;
  logic          bit_inc;
  logic          commit_en;

  // pad_data is asynchronous to system_clk; nothing past sync_q ever sees it raw.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= pad.pad_data;
      sync_q      <= sync_meta_q;
    end
  end

  assign latch_end = (phase_q == LATCH_LAST);
  assign half_end  = (phase_q == HALF_LAST);
  assign bit_end   = (bit_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pad.poll) state_d = S_LATCH;
      S_LATCH:  if (latch_end) state_d = S_LOW;
      S_LOW:    if (half_end) state_d = S_HIGH;
      S_HIGH:   if (half_end) state_d = bit_end ? S_COMMIT : S_LOW;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pad.pad_latch = 1'b0;
    pad.pad_clk   = 1'b1;
    pad.busy      = 1'b1;
    pad.done      = 1'b0;
    pad.changed   = 1'b0;
    scan_start    = 1'b0;
    sample_en     = 1'b0;
    bit_inc       = 1'b0;
    commit_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        pad.busy   = 1'b0;
        scan_start = pad.poll;
      end
      S_LATCH: pad.pad_latch = 1'b1;
      S_LOW: begin
        pad.pad_clk = 1'b0;
        sample_en   = half_end;
      end
      S_HIGH: bit_inc = half_end && !bit_end;
      S_COMMIT: begin
        pad.done  = 1'b1;
        commit_en = 1'b1;
        // A change is only reported when the debounced value actually moves.
        pad.changed = (shift_q == prev_q) && (shift_q != buttons_q);
      end
      default: pad.busy = 1'b0;
    endcase
  end

  // Phase restarts on every state change so each phase length is counted from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      prev_q    <= '0;
      buttons_q <= '0;
    end else begin
      if (state_q == S_IDLE || state_d != state_q) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + PW'(1);
      end

      if (state_q == S_IDLE) begin
        bit_q <= '0;
      end else if (bit_inc) begin
        bit_q <= bit_q + BW'(1);
      end

      if (scan_start) begin
        shift_q <= '0;
      end else if (sample_en) begin
        shift_q[4'(bit_q)] <= ~sync_q;
      end

      if (commit_en) begin
        prev_q <= shift_q;
        if (shift_q == prev_q) begin
          buttons_q <= shift_q;
        end
      end
    end
  end

  assign pad.buttons = buttons_q;
  assign dbg_state   = state_q;

endmodule
